// File: rtl/tetris_mem_pkg.sv
// Shared widths and enums for the tetris memory arbiter slice.
package tetris_mem_pkg;
    localparam int MEM_AW  = 15;
    localparam int MEM_DW  = 32;
    localparam int MEM_BEW = 4;

    typedef enum logic {IDLE, CLEAR} arb_state_t;
    typedef enum logic {PORT_V, PORT_G} port_t;
endpackage

// File: rtl/tetris_clr_engine.sv
// Board-clear engine: walks a word range and requests one zero-write per grant.
// state | meaning
// IDLE  | no clear running; game is the secondary requester
// CLEAR | zero-filling from clr_ptr, clr_cnt words left; clear is the secondary
module tetris_clr_engine
    import tetris_mem_pkg::*;
#(
    parameter logic [MEM_AW-1:0] CLR_BASE  = 15'h0000,
    parameter logic [15:0]       CLR_WORDS = 16'd200
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              gnt,
    output arb_state_t        state,
    output logic              req,
    output logic [MEM_AW-1:0] ptr,
    output logic              busy,
    output logic              done
);
    logic [15:0] cnt;

    assign req = (state == CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        ptr   <= CLR_BASE;
                        cnt   <= CLR_WORDS;
                    end
                end
                CLEAR: begin
                    if (gnt) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == 16'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/tetris_mem_arbiter.sv
// Arbitrates the single-port game memory between video, game logic and the clear engine.
// Video has priority; a starvation counter forces the secondary through periodically.
module tetris_mem_arbiter
    import tetris_mem_pkg::*;
#(
    parameter int                STARVE_LIMIT = 4,
    parameter logic [MEM_AW-1:0] CLR_BASE     = 15'h0000,
    parameter logic [15:0]       CLR_WORDS    = 16'd200
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               v_req,
    input  logic [MEM_AW-1:0]  v_addr,
    output logic               v_gnt,
    output logic               v_rvalid,
    output logic [MEM_DW-1:0]  v_rdata,
    input  logic               g_req,
    input  logic               g_we,
    input  logic [MEM_AW-1:0]  g_addr,
    input  logic [MEM_BEW-1:0] g_be,
    input  logic [MEM_DW-1:0]  g_wdata,
    output logic               g_gnt,
    output logic               g_rvalid,
    output logic [MEM_DW-1:0]  g_rdata,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    input  logic               hold,
    output logic [MEM_AW-1:0]  mem_address,
    output logic [MEM_BEW-1:0] mem_byteenable,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic [MEM_DW-1:0]  mem_writedata,
    output logic               mem_clken,
    input  logic [MEM_DW-1:0]  mem_readdata
);
    localparam int              SW         = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t        state;
    logic              clr_req, clr_gnt, sec_req, sec_gnt;
    logic [MEM_AW-1:0] clr_ptr;
    logic [SW-1:0]     starve_cnt;
    logic              arb_en, rd_pend;
    port_t             rd_port;

    tetris_clr_engine #(
        .CLR_BASE  (CLR_BASE),
        .CLR_WORDS (CLR_WORDS)
    ) u_clr (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (clr_start),
        .gnt     (clr_gnt),
        .state   (state),
        .req     (clr_req),
        .ptr     (clr_ptr),
        .busy    (clr_busy),
        .done    (clr_done)
    );

    always_comb begin
        sec_req = (state == IDLE) ? g_req : clr_req;
        v_gnt   = 1'b0;
        sec_gnt = 1'b0;
        // arb_en keeps grants off while reset is asserted, even with requests high
        if (arb_en && !hold) begin
            if (sec_req && (!v_req || starve_cnt == STARVE_MAX))
                sec_gnt = 1'b1;
            else if (v_req)
                v_gnt = 1'b1;
        end
        g_gnt   = sec_gnt && (state == IDLE);
        clr_gnt = sec_gnt && (state == CLEAR);
    end

    always_comb begin
        mem_chipselect = v_gnt | sec_gnt;
        mem_write      = clr_gnt | (g_gnt & g_we);
        mem_address    = v_addr;
        mem_byteenable = '1;
        mem_writedata  = '0;
        if (clr_gnt) begin
            mem_address = clr_ptr;
        end else if (g_gnt) begin
            mem_address    = g_addr;
            mem_byteenable = g_be;
            mem_writedata  = g_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_en     <= 1'b0;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_port    <= PORT_V;
        end else begin
            arb_en  <= 1'b1;
            rd_pend <= v_gnt | (g_gnt & ~g_we);
            rd_port <= v_gnt ? PORT_V : PORT_G;
            if (!hold) begin
                if (!sec_req || sec_gnt)
                    starve_cnt <= '0;
                else if (v_gnt && starve_cnt != STARVE_MAX)
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign v_rvalid  = rd_pend && (rd_port == PORT_V);
    assign g_rvalid  = rd_pend && (rd_port == PORT_G);
    assign v_rdata   = mem_readdata;
    assign g_rdata   = mem_readdata;
    assign mem_clken = 1'b1;
endmodule
